// File: rtl/mux2_arb_pkg.sv
// Shared types and constants for the two-source round-robin mux arbiter.
// The state codes double as the one-hot grant vector.
package mux2_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        G0   = 2'b01,
        G1   = 2'b10
    } arb_state_e;

    localparam logic SEL_SRC0 = 1'b0;
    localparam logic SEL_SRC1 = 1'b1;

endpackage

// File: rtl/arb_mux2.sv
// Combinational WIDTH-bit 2:1 mux with an enable.
// The output is forced to zero while the enable is low.
module arb_mux2
    import mux2_arb_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic             en,
    input  logic             sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    assign y = en ? ((sel == SEL_SRC1) ? b : a) : '0;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Two-requester round-robin arbiter that owns the select of a shared 2:1 mux.
// An owner keeps the grant until it releases, or for MAX_HOLD cycles while the other side waits.
module mux2_rr_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int WIDTH    = 10,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] din0,
    input  logic [WIDTH-1:0] din1,
    output logic [1:0]       grant,
    output logic             sel,
    output logic [WIDTH-1:0] dout,
    output logic             busy
);

    localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD - 1);

    arb_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;

    // last_q resets to 1 so that source 0 wins the first tie.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;

        case (state_q)
            IDLE: begin
                if (req == 2'b01)      state_d = G0;
                else if (req == 2'b10) state_d = G1;
                else if (req == 2'b11) state_d = last_q ? G0 : G1;
            end
            G0: begin
                if (!req[0])                        state_d = req[1] ? G1 : IDLE;
                else if (req[1] && cnt_q == CNT_MAX) state_d = G1;
            end
            G1: begin
                if (!req[1])                        state_d = req[0] ? G0 : IDLE;
                else if (req[0] && cnt_q == CNT_MAX) state_d = G0;
            end
            default: state_d = IDLE;
        endcase

        // Any state change restarts the hold count; staying in a grant counts up and saturates.
        if (state_d != state_q) begin
            cnt_d = '0;
            if (state_d == G0)      last_d = 1'b0;
            else if (state_d == G1) last_d = 1'b1;
        end else if (state_q != IDLE && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign grant = state_q;
    assign sel   = (state_q == G1) ? SEL_SRC1 : SEL_SRC0;
    assign busy  = (state_q != IDLE);

    arb_mux2 #(
        .WIDTH (WIDTH)
    ) u_mux (
        .en  (busy),
        .sel (sel),
        .a   (din0),
        .b   (din1),
        .y   (dout)
    );

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Scoreboard-driven bench for mux2_rr_arbiter: each step pushes (req, expected grant),
// then the queue is drained one clock per entry and the outputs are compared.
module tb_mux2_rr_arbiter;

    localparam int WIDTH = 10;

    typedef struct {
        logic [1:0] req;
        logic [1:0] grant;
    } sbEntry_t;

    logic             clk;
    logic             resetn;
    logic [1:0]       req;
    logic [WIDTH-1:0] din0;
    logic [WIDTH-1:0] din1;
    logic [1:0]       grant;
    logic             sel;
    logic [WIDTH-1:0] dout;
    logic             busy;

    sbEntry_t sbQ[$];
    int       errorCount;
    int       checkCount;

    mux2_rr_arbiter #(
        .WIDTH    (WIDTH),
        .MAX_HOLD (4)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .req    (req),
        .din0   (din0),
        .din1   (din1),
        .grant  (grant),
        .sel    (sel),
        .dout   (dout),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected shared output for a given expected grant and the live source data.
    function automatic logic [WIDTH-1:0] expDout(input logic [1:0] g);
        if (g == 2'b01)      return din0;
        else if (g == 2'b10) return din1;
        else                 return '0;
    endfunction

    task automatic pushExp(input logic [1:0] r, input logic [1:0] g);
        sbEntry_t e;
        e.req   = r;
        e.grant = g;
        sbQ.push_back(e);
    endtask

    // Drive one request pattern and sample one time unit after the next rising edge.
    task automatic applyStimulus(input logic [1:0] r);
        req = r;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        req    = 2'b11;
        repeat (2) @(posedge clk);
        #1;
        checkCount++;
        if (grant !== 2'b00) begin errorCount++; $display("[TB] FAIL reset_grant got=%b exp=00", grant); end
        checkCount++;
        if (sel !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_sel got=%b exp=0", sel); end
        checkCount++;
        if (dout !== '0) begin errorCount++; $display("[TB] FAIL reset_dout got=%h exp=000", dout); end
        checkCount++;
        if (busy !== 1'b0) begin errorCount++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        checkCount++;
        if (grant !== 2'b01) begin errorCount++; $display("[TB] FAIL reset_first_grant got=%b exp=01", grant); end
        checkCount++;
        if (dout !== 10'h155) begin errorCount++; $display("[TB] FAIL reset_first_dout got=%h exp=155", dout); end
    endtask

    task automatic test_single();
        sbEntry_t e;
        pushExp(2'b00, 2'b00);
        repeat (6) pushExp(2'b10, 2'b10);
        pushExp(2'b00, 2'b00);
        while (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            applyStimulus(e.req);
            checkCount++;
            if (grant !== e.grant) begin errorCount++; $display("[TB] FAIL single_grant got=%b exp=%b", grant, e.grant); end
            checkCount++;
            if (dout !== expDout(e.grant)) begin errorCount++; $display("[TB] FAIL single_dout got=%h exp=%h", dout, expDout(e.grant)); end
            checkCount++;
            if ({sel, busy} !== {e.grant[1], e.grant != 2'b00}) begin
                errorCount++; $display("[TB] FAIL single_selbusy got=%b%b exp=%b%b", sel, busy, e.grant[1], e.grant != 2'b00);
            end
        end
    endtask

    task automatic test_forced_handover();
        sbEntry_t e;
        pushExp(2'b00, 2'b00);
        repeat (4) pushExp(2'b11, 2'b01);
        repeat (4) pushExp(2'b11, 2'b10);
        repeat (4) pushExp(2'b11, 2'b01);
        while (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            applyStimulus(e.req);
            checkCount++;
            if (grant !== e.grant) begin errorCount++; $display("[TB] FAIL forced_grant got=%b exp=%b", grant, e.grant); end
            checkCount++;
            if (dout !== expDout(e.grant)) begin errorCount++; $display("[TB] FAIL forced_dout got=%h exp=%h", dout, expDout(e.grant)); end
            checkCount++;
            if ({sel, busy} !== {e.grant[1], e.grant != 2'b00}) begin
                errorCount++; $display("[TB] FAIL forced_selbusy got=%b%b exp=%b%b", sel, busy, e.grant[1], e.grant != 2'b00);
            end
        end
    endtask

    // Last winner was source 0, so a tie from idle must go to source 1.
    task automatic test_tie_from_idle();
        sbEntry_t e;
        pushExp(2'b00, 2'b00);
        pushExp(2'b11, 2'b10);
        pushExp(2'b00, 2'b00);
        while (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            applyStimulus(e.req);
            checkCount++;
            if (grant !== e.grant) begin errorCount++; $display("[TB] FAIL tie_grant got=%b exp=%b", grant, e.grant); end
            checkCount++;
            if (dout !== expDout(e.grant)) begin errorCount++; $display("[TB] FAIL tie_dout got=%h exp=%h", dout, expDout(e.grant)); end
        end
    endtask

    task automatic test_voluntary_release();
        sbEntry_t e;
        pushExp(2'b00, 2'b00);
        pushExp(2'b01, 2'b01);
        pushExp(2'b01, 2'b01);
        pushExp(2'b10, 2'b10);
        while (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            applyStimulus(e.req);
            checkCount++;
            if (grant !== e.grant) begin errorCount++; $display("[TB] FAIL voluntary_grant got=%b exp=%b", grant, e.grant); end
            checkCount++;
            if (dout !== expDout(e.grant)) begin errorCount++; $display("[TB] FAIL voluntary_dout got=%h exp=%h", dout, expDout(e.grant)); end
            checkCount++;
            if (sel !== e.grant[1]) begin errorCount++; $display("[TB] FAIL voluntary_sel got=%b exp=%b", sel, e.grant[1]); end
        end
    endtask

    // Release lands on the timeout edge; the three extra 01 cycles prove the count restarted at zero.
    task automatic test_release_at_timeout();
        sbEntry_t e;
        pushExp(2'b00, 2'b00);
        pushExp(2'b10, 2'b10);
        repeat (3) pushExp(2'b11, 2'b10);
        pushExp(2'b01, 2'b01);
        repeat (3) pushExp(2'b11, 2'b01);
        pushExp(2'b11, 2'b10);
        while (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            applyStimulus(e.req);
            checkCount++;
            if (grant !== e.grant) begin errorCount++; $display("[TB] FAIL coincident_grant got=%b exp=%b", grant, e.grant); end
            checkCount++;
            if (dout !== expDout(e.grant)) begin errorCount++; $display("[TB] FAIL coincident_dout got=%h exp=%h", dout, expDout(e.grant)); end
        end
    endtask

    task automatic test_passthrough();
        sbEntry_t e;
        pushExp(2'b10, 2'b10);
        while (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            applyStimulus(e.req);
            checkCount++;
            if (grant !== e.grant) begin errorCount++; $display("[TB] FAIL pass_grant got=%b exp=%b", grant, e.grant); end
        end
        din1 = 10'h0F3;
        #1;
        checkCount++;
        if (dout !== 10'h0F3) begin errorCount++; $display("[TB] FAIL pass_din1 got=%h exp=0f3", dout); end
        din0 = 10'h3C1;
        #1;
        checkCount++;
        if (dout !== 10'h0F3) begin errorCount++; $display("[TB] FAIL pass_din0_ignored got=%h exp=0f3", dout); end
        din0 = 10'h155;
        din1 = 10'h2AA;
    endtask

    task automatic test_async_reset();
        sbEntry_t e;
        pushExp(2'b10, 2'b10);
        while (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            applyStimulus(e.req);
            checkCount++;
            if (grant !== e.grant) begin errorCount++; $display("[TB] FAIL async_pre_grant got=%b exp=%b", grant, e.grant); end
        end
        #2;
        resetn = 1'b0;
        #1;
        checkCount++;
        if (grant !== 2'b00) begin errorCount++; $display("[TB] FAIL async_grant got=%b exp=00", grant); end
        checkCount++;
        if (dout !== '0) begin errorCount++; $display("[TB] FAIL async_dout got=%h exp=000", dout); end
        checkCount++;
        if ({sel, busy} !== 2'b00) begin errorCount++; $display("[TB] FAIL async_selbusy got=%b%b exp=00", sel, busy); end
        @(negedge clk);
        resetn = 1'b1;
        req    = 2'b11;
        @(posedge clk);
        #1;
        checkCount++;
        if (grant !== 2'b01) begin errorCount++; $display("[TB] FAIL async_after_grant got=%b exp=01", grant); end
        checkCount++;
        if (dout !== 10'h155) begin errorCount++; $display("[TB] FAIL async_after_dout got=%h exp=155", dout); end
    endtask

    initial begin
        errorCount = 0;
        checkCount = 0;
        resetn     = 1'b0;
        req        = 2'b00;
        din0       = 10'h155;
        din1       = 10'h2AA;

        test_reset();
        test_single();
        test_forced_handover();
        test_tie_from_idle();
        test_voluntary_release();
        test_release_at_timeout();
        test_passthrough();
        test_async_reset();

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/mux2_rr_arbiter.md
Name: mux2_rr_arbiter

Overview:
Two-requester round-robin arbiter that shares one WIDTH-bit 2:1 mux output between two sources. It owns the mux select: it decides which source drives the shared output, holds a grant while the owner keeps requesting, and forces a hand-over after MAX_HOLD cycles if the other side is waiting. It sits between the switch/source inputs and the shared LED/output bus, replacing a hand-driven select line.

Parameters:
WIDTH, 10, data width of each source and of the shared output
MAX_HOLD, 4, maximum consecutive granted cycles before a forced hand-over when the other requester is waiting (legal range 2 to 255)

Ports:
clk  input  1  single system clock, rising edge
resetn  input  1  asynchronous active-low reset
req  input  2  req[i]=1: source i wants the shared output
din0  input  WIDTH  source 0 data
din1  input  WIDTH  source 1 data
grant  output  2  one-hot registered grant, 00 when idle
sel  output  1  registered mux select, 0=din0, 1=din1
dout  output  WIDTH  shared output: din[sel] when grant!=00, else all zeros
busy  output  1  1 when grant!=00

Behaviour:
- Reset (async, resetn=0): state=IDLE, grant=00, sel=0, busy=0, dout=0, hold counter cnt=0, last-served pointer last=1, so source 0 wins the first tie. Release is synchronous to the next rising clk.
- States: IDLE, G0, G1. Encoding is one-hot or binary. grant, sel and busy decode directly from the state register, with no combinational path from req.
- Latency: a req sampled at edge N gives grant at edge N+1. dout is combinational from the registered sel/grant and the live din, with zero latency from din.
- IDLE: req=01 -> G0; req=10 -> G1; req=11 -> G(~last); req=00 -> stay.
- Gi, per edge:
  - req[i]=0 and req[~i]=1 -> G(~i) directly, with no idle bubble.
  - req[i]=0 and req[~i]=0 -> IDLE.
  - req[i]=1 and cnt==MAX_HOLD-1 and req[~i]=1 -> G(~i) (forced hand-over).
  - Otherwise stay in Gi.
- Hold counter:
  - cnt=0 on every entry to Gi.
  - cnt increments each cycle spent in Gi and saturates at MAX_HOLD-1. With no competitor, the owner keeps the grant indefinitely.
  - Width is clog2(MAX_HOLD).
- last updates to i on every entry to Gi.
- Simultaneous events: the owner dropping req in the same cycle the timeout is reached is treated as a normal release (same next state). A new request from the non-owner never pre-empts before the timeout.
- Reset mid-grant: grant, sel and dout drop to their reset values immediately (asynchronously). No grant survives reset.
- Invariants: grant is never 11. sel is only changed together with a grant change. dout=0 whenever busy=0.

Decomposition:
- Shared package mux2_arb_pkg holds:
  - the state typedef (IDLE, G0, G1);
  - the constants SEL_SRC0=0 and SEL_SRC1=1.
- One natural sub-module, arb_mux2: a purely combinational WIDTH-bit 2:1 mux with an enable, where dout = en ? (sel ? b : a) : 0.
- The arbiter instantiates arb_mux2 with en=busy. The FSM and counter stay in the top module.

Test Plan (WIDTH=10, MAX_HOLD=4, din0=10'h155, din1=10'h2AA):
- Reset: hold resetn=0 with req=11 -> grant=00, sel=0, dout=0, busy=0. Release resetn and drive req=11 -> one edge later grant=01, dout=10'h155.
- Single requester: req=10 for 6 cycles, then 00 -> grant=10 from the cycle after req rises and holds all 6 cycles (cnt saturates, no hand-over). grant=00 and dout=0 one edge after req falls.
- Forced hand-over: req=11 held -> grant sequence 01 x4, 10 x4, 01 x4. dout alternates 155/2AA on exactly those boundaries, with no idle cycle between.
- Voluntary release: in G0 at cnt=1, drop req[0] while req[1]=1 -> next edge grant=10, sel=1, dout=10'h2AA.
- Release and timeout coincident: at cnt=3 in G1, req goes 11 -> 01 on the same edge -> next state G0 with cnt=0, never IDLE.
- Async reset mid-grant: assert resetn=0 between clock edges while in G1 -> grant=00 and dout=0 immediately, without waiting for clk. After release, req=11 gives G0 first, because last was reset to 1.
